// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared definitions for the instruction sequencer.
// Holds the sequencer state encoding used by the top-level FSM.
package cpu_sequencer_pkg;

    // Instruction phases. FETCH must stay the reset/idle state.
    typedef enum logic [2:0] {
        SEQ_FETCH     = 3'd0,
        SEQ_DECODE    = 3'd1,
        SEQ_EXECUTE   = 3'd2,
        SEQ_ATC_WAIT  = 3'd3,
        SEQ_WRITEBACK = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_next_ip_select.sv
// next_ip_select: combinational next-instruction-pointer mux.
// Ports:
//   ip          - current instruction pointer
//   jump_target - branch destination
//   take_branch - 1 selects jump_target, 0 selects ip+1 (wraps)
//   next_ip     - selected next pointer
module next_ip_select #(
    parameter int IP_WIDTH = 8
) (
    input  logic [IP_WIDTH-1:0] ip,
    input  logic [IP_WIDTH-1:0] jump_target,
    input  logic                take_branch,
    output logic [IP_WIDTH-1:0] next_ip
);

    // Carry out of the increment is dropped so the pointer wraps.
    assign next_ip = take_branch ? jump_target : ip + IP_WIDTH'(1);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback sequencer.
// Owns the instruction pointer, requests program memory with req/ack and
// arbitrates Atomic Test-and-Clear access to the shared flag.
// Ports:
//   clk, reset                 - clock; async active-high reset
//   run                        - permits a new fetch to start
//   fetch_req/fetch_addr/ack   - program memory handshake (addr == ip)
//   instr_load                 - instruction register load strobe
//   write_enable/branch_select/is_atc/cond_true/jump_target - decoded controls
//   reg_we                     - register file write strobe
//   atc_req/atc_grant/atc_flag/atc_clear - flag resource handshake
//   ip                         - current instruction pointer
//   retire                     - one-cycle instruction completion pulse
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int                     IP_WIDTH = 8,
    parameter logic [IP_WIDTH-1:0]    START_IP = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                fetch_req,
    output logic [IP_WIDTH-1:0] fetch_addr,
    input  logic                fetch_ack,
    output logic                instr_load,
    input  logic                write_enable,
    input  logic                branch_select,
    input  logic                is_atc,
    input  logic                cond_true,
    input  logic [IP_WIDTH-1:0] jump_target,
    output logic                reg_we,
    output logic                atc_req,
    input  logic                atc_grant,
    input  logic                atc_flag,
    output logic                atc_clear,
    output logic [IP_WIDTH-1:0] ip,
    output logic                retire
);

    seq_state_t          state;
    logic                take_branch;
    logic [IP_WIDTH-1:0] next_ip;

    // ATC reuses the branch mux: a set flag acts like a taken jump.
    always_comb begin
        take_branch = 1'b0;
        if (state == SEQ_ATC_WAIT)
            take_branch = atc_flag;
        else if (state == SEQ_EXECUTE)
            take_branch = branch_select & cond_true;
    end

    next_ip_select #(
        .IP_WIDTH    (IP_WIDTH)
    ) u_next_ip (
        .ip          (ip),
        .jump_target (jump_target),
        .take_branch (take_branch),
        .next_ip     (next_ip)
    );

    assign fetch_addr = ip;

    // Strobes are decoded from state plus same-cycle inputs. Gating with
    // !reset makes every request/strobe drop the instant reset rises,
    // not just once the state register has been cleared.
    always_comb begin
        fetch_req  = 1'b0;
        instr_load = 1'b0;
        reg_we     = 1'b0;
        atc_req    = 1'b0;
        atc_clear  = 1'b0;
        retire     = 1'b0;
        if (!reset) begin
            case (state)
                SEQ_FETCH: begin
                    fetch_req  = run;
                    instr_load = run & fetch_ack;
                end
                SEQ_EXECUTE: begin
                    retire = ~is_atc & (branch_select | ~write_enable);
                end
                SEQ_ATC_WAIT: begin
                    atc_req   = 1'b1;
                    atc_clear = atc_grant & atc_flag;
                    retire    = atc_grant;
                end
                SEQ_WRITEBACK: begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEQ_FETCH;
            ip    <= START_IP;
        end else begin
            case (state)
                SEQ_FETCH: begin
                    if (instr_load)
                        state <= SEQ_DECODE;
                end
                SEQ_DECODE: begin
                    state <= SEQ_EXECUTE;
                end
                SEQ_EXECUTE: begin
                    if (is_atc) begin
                        state <= SEQ_ATC_WAIT;
                    end else begin
                        // branch, write and NOP all advance ip here
                        ip    <= next_ip;
                        state <= (!branch_select && write_enable) ? SEQ_WRITEBACK
                                                                  : SEQ_FETCH;
                    end
                end
                SEQ_ATC_WAIT: begin
                    if (atc_grant) begin
                        ip    <= next_ip;
                        state <= SEQ_FETCH;
                    end
                end
                SEQ_WRITEBACK: begin
                    state <= SEQ_FETCH;
                end
                default: begin
                    state <= SEQ_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench. Each instruction is expanded into the
// per-cycle output trace its type must produce; a compare process checks
// the DUT against that trace every cycle. Literal pins anchor key values.
module tb_cpu_sequencer;

    localparam logic [7:0] START = 8'h00;
    localparam int K_NOP = 0, K_BR = 1, K_WR = 2, K_ATC = 3;

    typedef struct packed {
        logic       run, ack, we, br, atc, cond;
        logic [7:0] tgt;
        logic       grant, flag, rst;
    } in_t;

    typedef struct packed {
        logic       freq;
        logic [7:0] addr;
        logic       load, we, areq, aclr, ret;
        logic [7:0] ip;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, fetch_ack = 1'b0;
    logic       write_enable = 1'b0, branch_select = 1'b0, is_atc = 1'b0, cond_true = 1'b0;
    logic [7:0] jump_target = 8'h00;
    logic       atc_grant = 1'b0, atc_flag = 1'b0;
    logic       fetch_req, instr_load, reg_we, atc_req, atc_clear, retire;
    logic [7:0] fetch_addr, ip;

    int checks = 0;
    int passed = 0;
    int areq_n = 0;
    int aclr_n = 0;
    logic [7:0] mip = START;
    exp_t expq[$];

    cpu_sequencer #(.IP_WIDTH(8), .START_IP(START)) dut (
        .clk(clk), .reset(reset), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .instr_load(instr_load), .write_enable(write_enable),
        .branch_select(branch_select), .is_atc(is_atc), .cond_true(cond_true),
        .jump_target(jump_target), .reg_we(reg_we), .atc_req(atc_req),
        .atc_grant(atc_grant), .atc_flag(atc_flag), .atc_clear(atc_clear),
        .ip(ip), .retire(retire)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        actual = {fetch_req, fetch_addr, instr_load, reg_we, atc_req, atc_clear, retire, ip};
    endfunction

    function automatic exp_t idle(input logic [7:0] v);
        idle = '0;
        idle.ip = v;
        idle.addr = v;
    endfunction

    // Per-cycle trace compare.
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            exp_t a;
            e = expq.pop_front();
            a = actual();
            checks++;
            if (a === e) passed++;
            else $display("FAIL trace t=%0t got=%h required=%h", $time, a, e);
        end
    end

    always @(negedge clk) begin
        if (atc_req) areq_n++;
        if (atc_clear) aclr_n++;
    end

    task automatic check(input string nm, input int got, input int req);
        checks++;
        if (got == req) passed++;
        else $display("FAIL %s got=%0d required=%0d", nm, got, req);
    endtask

    // One cycle: apply inputs just after the edge, queue the expected outputs.
    task automatic step(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        run = i.run; fetch_ack = i.ack; write_enable = i.we; branch_select = i.br;
        is_atc = i.atc; cond_true = i.cond; jump_target = i.tgt;
        atc_grant = i.grant; atc_flag = i.flag; reset = i.rst;
        expq.push_back(e);
    endtask

    // Step, or at cycle rst_at show the normal outputs, then assert reset
    // mid-cycle and require everything to drop at once.
    task automatic go(input in_t i, input exp_t e, input int rst_at, inout int c, output bit ab);
        in_t z;
        ab = 1'b0;
        if (c == rst_at) begin
            step(i, idle(START));
            #1 check("pre_reset_trace", int'(actual() === e), 1);
            reset = 1'b1;
            #1 check("reset_drop", int'({fetch_req, instr_load, reg_we, atc_req, atc_clear, retire}), 0);
            check("reset_ip", int'(ip), int'(START));
            z = '0;
            step(z, idle(START));
            mip = START;
            ab = 1'b1;
        end else begin
            step(i, e);
        end
        c++;
    endtask

    task automatic instr(input int kind, input int aw, input int gw, input logic cond,
                         input logic flag, input logic [7:0] tgt, input int rst_at);
        in_t i;
        exp_t e;
        int c;
        bit ab;
        logic [7:0] nip;
        c = 0;
        i = '0;
        i.tgt = tgt; i.cond = cond; i.flag = flag; i.run = 1'b1;
        for (int k = 0; k < aw; k++) begin
            e = idle(mip); e.freq = 1'b1;
            go(i, e, rst_at, c, ab); if (ab) return;
        end
        i.ack = 1'b1;
        e = idle(mip); e.freq = 1'b1; e.load = 1'b1;
        go(i, e, rst_at, c, ab); if (ab) return;
        // decode: controls valid; run dropped, stray ack/grant must be ignored
        i.run = 1'b0; i.grant = 1'b1;
        i.we = (kind == K_WR); i.br = (kind == K_BR); i.atc = (kind == K_ATC);
        e = idle(mip);
        go(i, e, rst_at, c, ab); if (ab) return;
        e = idle(mip);
        case (kind)
            K_NOP:   begin e.ret = 1'b1; nip = mip + 8'd1; end
            K_BR:    begin e.ret = 1'b1; nip = cond ? tgt : mip + 8'd1; end
            K_WR:    nip = mip + 8'd1;
            default: nip = mip;
        endcase
        go(i, e, rst_at, c, ab); if (ab) return;
        mip = nip;
        if (kind == K_WR) begin
            e = idle(mip); e.we = 1'b1; e.ret = 1'b1;
            go(i, e, rst_at, c, ab); if (ab) return;
        end
        if (kind == K_ATC) begin
            i.grant = 1'b0;
            for (int k = 0; k < gw; k++) begin
                e = idle(mip); e.areq = 1'b1;
                go(i, e, rst_at, c, ab); if (ab) return;
            end
            i.grant = 1'b1;
            e = idle(mip); e.areq = 1'b1; e.aclr = flag; e.ret = 1'b1;
            go(i, e, rst_at, c, ab); if (ab) return;
            mip = flag ? tgt : mip + 8'd1;
        end
    endtask

    task automatic fetch_hold(input int n);
        in_t i;
        i = '0; i.ack = 1'b1;
        for (int k = 0; k < n; k++) step(i, idle(mip));
    endtask

    // Literal pin on ip/fetch_addr after the last edge of an instruction.
    task automatic pin(input string nm, input logic [7:0] v);
        @(posedge clk);
        #2;
        checks++;
        if (ip === v && fetch_addr === v) passed++;
        else $display("FAIL %s ip=%h fetch_addr=%h required=%h", nm, ip, fetch_addr, v);
    endtask

    initial begin
        in_t r;
        int a0, c0;
        r = '0; r.rst = 1'b1; r.run = 1'b1; r.ack = 1'b1;
        step(r, idle(START));
        step(r, idle(START));
        #1 check("reset_state_ip", int'(ip), 0);

        for (int k = 0; k < 4; k++) instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        pin("nop_ip4", 8'h04);
        instr(K_WR, 0, 0, 0, 0, 8'h00, -1);
        pin("write_ip5", 8'h05);
        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        instr(K_BR, 0, 0, 1, 0, 8'h20, -1);
        pin("jump_taken", 8'h20);
        instr(K_BR, 0, 0, 1, 0, 8'h07, -1);
        instr(K_BR, 0, 0, 0, 0, 8'h20, -1);
        pin("jump_not_taken", 8'h08);

        a0 = areq_n; c0 = aclr_n;
        instr(K_ATC, 0, 3, 0, 1, 8'h40, -1);
        pin("atc_set_ip", 8'h40);
        check("atc_set_req_cycles", areq_n - a0, 4);
        check("atc_set_clears", aclr_n - c0, 1);
        a0 = areq_n; c0 = aclr_n;
        instr(K_ATC, 0, 3, 0, 0, 8'h10, -1);
        pin("atc_clr_ip", 8'h41);
        check("atc_clr_req_cycles", areq_n - a0, 4);
        check("atc_clr_clears", aclr_n - c0, 0);

        instr(K_NOP, 2, 0, 0, 0, 8'h00, -1);
        pin("ack_wait_ip", 8'h42);
        fetch_hold(3);
        pin("run_low_ip", 8'h42);
        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);

        instr(K_BR, 1, 0, 1, 0, 8'hFE, -1);
        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        pin("ip_wrap", 8'h00);

        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        instr(K_WR, 0, 0, 0, 0, 8'h00, 3);
        instr(K_NOP, 0, 0, 0, 0, 8'h00, -1);
        instr(K_ATC, 0, 3, 0, 1, 8'h40, 4);
        instr(K_NOP, 1, 0, 0, 0, 8'h00, -1);
        pin("after_reset_ip", 8'h01);

        @(posedge clk);
        #6;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
